// File: rtl/muldiv_pkg.sv
// Shared types and constants for the multicycle multiply/divide unit.
// Build option: MULDIV_DIV_EN enables the restoring divider datapath.
package muldiv_pkg;

   localparam int unsigned WIDTH = 32;
   localparam int unsigned ACC_W = 2 * WIDTH;
   localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

   typedef enum logic [1:0] {
      OP_MULT  = 2'b00,
      OP_MULTU = 2'b01,
      OP_DIV   = 2'b10,
      OP_DIVU  = 2'b11
   } op_t;

   typedef enum logic [2:0] {
      IDLE,
      PREP,
      MUL,
      DIV,
      FIX,
      DONE
   } state_t;

   // Two's-complement negate when neg is set; used for magnitudes and sign fix-up.
   function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] x, input logic neg);
      return neg ? (~x + WIDTH'(1)) : x;
   endfunction

endpackage

// File: rtl/muldiv_if.sv
// Control-unit side bundle of the multiply/divide unit.
interface muldiv_if;
   import muldiv_pkg::*;

   logic             start;
   op_t              op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             abort;
   logic             wr_hi;
   logic             wr_lo;
   logic [WIDTH-1:0] din;
   logic             busy;
   logic             done;
   logic             div_zero;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;

   modport master (
      output start, op, a, b, abort, wr_hi, wr_lo, din,
      input  busy, done, div_zero, hi, lo
   );

   modport slave (
      input  start, op, a, b, abort, wr_hi, wr_lo, din,
      output busy, done, div_zero, hi, lo
   );

endinterface

// File: rtl/muldiv_step.sv
// One combinational multiply (shift-add) or divide (restoring) iteration.
// Build option: MULDIV_DIV_EN adds the divide path and the is_div_i select.
module muldiv_step
   import muldiv_pkg::*;
(
`ifdef MULDIV_DIV_EN
   input  logic             is_div_i,
`endif
   input  logic [ACC_W-1:0] acc_i,
   input  logic [WIDTH-1:0] opnd_i,
   output logic [ACC_W-1:0] acc_o
);

   logic [WIDTH:0]   mul_sum;
   logic [ACC_W-1:0] mul_nxt;

   // Multiply: low half holds the remaining multiplier bits; add and shift right.
   always_comb begin
      mul_sum = {1'b0, acc_i[ACC_W-1:WIDTH]} + (acc_i[0] ? {1'b0, opnd_i} : (WIDTH+1)'(0));
      mul_nxt = {mul_sum, acc_i[WIDTH-1:1]};
   end

`ifdef MULDIV_DIV_EN
   logic [WIDTH:0]   div_trial;
   logic [WIDTH:0]   div_diff;
   logic [WIDTH-1:0] div_rem;
   logic             div_qbit;

   // Divide: {remainder, quotient} shifts left; keep the subtraction when it does not borrow.
   always_comb begin
      div_trial = {acc_i[ACC_W-1:WIDTH], acc_i[WIDTH-1]};
      div_diff  = div_trial - {1'b0, opnd_i};
      div_qbit  = ~div_diff[WIDTH];
      div_rem   = div_qbit ? div_diff[WIDTH-1:0] : div_trial[WIDTH-1:0];
      acc_o     = is_div_i ? {div_rem, acc_i[WIDTH-2:0], div_qbit} : mul_nxt;
   end
`else
   assign acc_o = mul_nxt;
`endif

endmodule

// File: rtl/muldiv_unit.sv
// Multicycle multiply/divide unit owning the architectural HI/LO registers.
// Build option: MULDIV_DIV_EN enables DIV/DIVU; without it divides finish
// early with DivZero set and HI/LO untouched.
module muldiv_unit
   import muldiv_pkg::*;
(
   input  logic     clk,
   input  logic     rst,
   muldiv_if.slave  mdu
);

   state_t           state_q;
   logic             is_div_q;
   logic             sa_q;
   logic             sb_q;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [ACC_W-1:0] acc_q;
   logic [CNT_W-1:0] cnt_q;
   logic [WIDTH-1:0] hi_q;
   logic [WIDTH-1:0] lo_q;
   logic             busy_q;
   logic             done_q;
   logic             dz_q;

   logic [ACC_W-1:0] acc_d;
   logic [ACC_W-1:0] prod_d;
   logic [WIDTH-1:0] hi_d;
   logic [WIDTH-1:0] lo_d;
   logic [WIDTH-1:0] opnd_d;

`ifdef MULDIV_DIV_EN
   assign opnd_d = is_div_q ? b_q : a_q;
`else
   assign opnd_d = a_q;
`endif

   muldiv_step u_step (
`ifdef MULDIV_DIV_EN
      .is_div_i (is_div_q),
`endif
      .acc_i    (acc_q),
      .opnd_i   (opnd_d),
      .acc_o    (acc_d)
   );

   // Sign fix-up of the finished magnitude result; signs are zero for unsigned ops.
   always_comb begin
      prod_d = (sa_q ^ sb_q) ? (~acc_q + ACC_W'(1)) : acc_q;
      hi_d   = prod_d[ACC_W-1:WIDTH];
      lo_d   = prod_d[WIDTH-1:0];
`ifdef MULDIV_DIV_EN
      if (is_div_q) begin
         hi_d = cond_neg(acc_q[ACC_W-1:WIDTH], sa_q);
         lo_d = cond_neg(acc_q[WIDTH-1:0], sa_q ^ sb_q);
      end
`endif
   end

   // Control FSM with all state, datapath and output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         is_div_q <= 1'b0;
         sa_q     <= 1'b0;
         sb_q     <= 1'b0;
         a_q      <= '0;
         b_q      <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         dz_q     <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (state_q != IDLE && mdu.abort) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            dz_q    <= 1'b0;
         end else begin
            case (state_q)
               IDLE: begin
                  if (mdu.start && !mdu.abort) begin
                     is_div_q <= mdu.op[1];
                     sa_q     <= ~mdu.op[0] & mdu.a[WIDTH-1];
                     sb_q     <= ~mdu.op[0] & mdu.b[WIDTH-1];
                     a_q      <= cond_neg(mdu.a, ~mdu.op[0] & mdu.a[WIDTH-1]);
                     b_q      <= cond_neg(mdu.b, ~mdu.op[0] & mdu.b[WIDTH-1]);
                     busy_q   <= 1'b1;
                     dz_q     <= 1'b0;
                     state_q  <= PREP;
                  end else begin
                     if (mdu.wr_hi) hi_q <= mdu.din;
                     if (mdu.wr_lo) lo_q <= mdu.din;
                  end
               end
               PREP: begin
                  if (is_div_q) begin
`ifdef MULDIV_DIV_EN
                     if (b_q == '0) begin
                        hi_q    <= cond_neg(a_q, sa_q);
                        lo_q    <= '1;
                        dz_q    <= 1'b1;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                     end else begin
                        acc_q   <= {WIDTH'(0), a_q};
                        cnt_q   <= CNT_W'(WIDTH);
                        state_q <= DIV;
                     end
`else
                     dz_q    <= 1'b1;
                     done_q  <= 1'b1;
                     state_q <= DONE;
`endif
                  end else begin
                     acc_q   <= {WIDTH'(0), b_q};
                     cnt_q   <= CNT_W'(WIDTH);
                     state_q <= MUL;
                  end
               end
               MUL: begin
                  acc_q <= acc_d;
                  cnt_q <= cnt_q - CNT_W'(1);
                  if (cnt_q == CNT_W'(1)) state_q <= FIX;
               end
`ifdef MULDIV_DIV_EN
               DIV: begin
                  acc_q <= acc_d;
                  cnt_q <= cnt_q - CNT_W'(1);
                  if (cnt_q == CNT_W'(1)) state_q <= FIX;
               end
`endif
               FIX: begin
                  hi_q    <= hi_d;
                  lo_q    <= lo_d;
                  done_q  <= 1'b1;
                  state_q <= DONE;
               end
               DONE: begin
                  busy_q  <= 1'b0;
                  dz_q    <= 1'b0;
                  state_q <= IDLE;
               end
               default: begin
                  busy_q  <= 1'b0;
                  dz_q    <= 1'b0;
                  state_q <= IDLE;
               end
            endcase
         end
      end
   end

   assign mdu.busy     = busy_q;
   assign mdu.done     = done_q;
   assign mdu.div_zero = dz_q;
   assign mdu.hi       = hi_q;
   assign mdu.lo       = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed, table-driven bench for muldiv_unit (handles MULDIV_DIV_EN on or off).
module tb_muldiv_unit;
   import muldiv_pkg::*;

   typedef struct {
      op_t         op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] hi;
      logic [31:0] lo;
      logic        dz;
      int          cyc;
   } vec_t;

   logic clk;
   logic rst;
   int   checks;
   int   errors;

   muldiv_if m ();

   muldiv_unit dut (
      .clk (clk),
      .rst (rst),
      .mdu (m)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // Launch one operation and wait (bounded) for Done; cyc = -1 if it never comes.
   task automatic run_op(input op_t op, input logic [31:0] a, input logic [31:0] b,
                         output int cyc, output logic [31:0] hi, output logic [31:0] lo,
                         output logic dz);
      cyc = -1;
      hi  = '0;
      lo  = '0;
      dz  = 1'b0;
      @(negedge clk);
      m.start = 1'b1;
      m.op    = op;
      m.a     = a;
      m.b     = b;
      for (int n = 1; n <= 100 && cyc < 0; n++) begin
         @(negedge clk);
         m.start = 1'b0;
         if (m.done) begin
            cyc = n;
            hi  = m.hi;
            lo  = m.lo;
            dz  = m.div_zero;
         end
      end
   endtask

   vec_t        vt [9];
   int          cyc;
   int          seen;
   logic [31:0] rhi;
   logic [31:0] rlo;
   logic        rdz;

   initial begin
      checks  = 0;
      errors  = 0;
      rst     = 1'b1;
      m.start = 1'b0;
      m.op    = OP_MULT;
      m.a     = '0;
      m.b     = '0;
      m.abort = 1'b0;
      m.wr_hi = 1'b0;
      m.wr_lo = 1'b0;
      m.din   = '0;

      vt[0] = '{OP_MULT,  32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 35};
      vt[1] = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 35};
      vt[2] = '{OP_MULT,  32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 35};
`ifdef MULDIV_DIV_EN
      vt[3] = '{OP_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 35};
      vt[4] = '{OP_DIVU,  32'hFFFFFFF9, 32'h00000002, 32'h00000001, 32'h7FFFFFFC, 1'b0, 35};
      vt[5] = '{OP_DIV,   32'h00000005, 32'h00000000, 32'h00000005, 32'hFFFFFFFF, 1'b1, 2};
      vt[6] = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 35};
      vt[7] = '{OP_DIVU,  32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E, 1'b0, 35};
      vt[8] = '{OP_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0, 35};
`else
      vt[3] = '{OP_DIV,   32'hFFFFFFF9, 32'h00000002, 32'h00000000, 32'h80000000, 1'b1, 2};
      vt[4] = '{OP_DIVU,  32'hFFFFFFF9, 32'h00000002, 32'h00000000, 32'h80000000, 1'b1, 2};
      vt[5] = '{OP_DIV,   32'h00000005, 32'h00000000, 32'h00000000, 32'h80000000, 1'b1, 2};
      vt[6] = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b1, 2};
      vt[7] = '{OP_DIVU,  32'h00000064, 32'h00000007, 32'h00000000, 32'h80000000, 1'b1, 2};
      vt[8] = '{OP_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000000, 32'h80000000, 1'b1, 2};
`endif

      // Reset state
      #12;
      chk("rst_busy", 32'(m.busy), 32'd0);
      chk("rst_done", 32'(m.done), 32'd0);
      chk("rst_dz",   32'(m.div_zero), 32'd0);
      chk("rst_hi",   m.hi, 32'd0);
      chk("rst_lo",   m.lo, 32'd0);
      @(negedge clk);
      rst = 1'b0;

      // Both write strobes in one cycle
      @(negedge clk);
      m.wr_hi = 1'b1;
      m.wr_lo = 1'b1;
      m.din   = 32'h0000ABCD;
      @(negedge clk);
      m.wr_hi = 1'b0;
      m.wr_lo = 1'b0;
      chk("wr_both_hi", m.hi, 32'h0000ABCD);
      chk("wr_both_lo", m.lo, 32'h0000ABCD);

      // Table-driven operations
      for (int i = 0; i < 9; i++) begin
         run_op(vt[i].op, vt[i].a, vt[i].b, cyc, rhi, rlo, rdz);
         chk($sformatf("vec%0d_cycle", i), 32'(cyc), 32'(vt[i].cyc));
         chk($sformatf("vec%0d_hi", i), rhi, vt[i].hi);
         chk($sformatf("vec%0d_lo", i), rlo, vt[i].lo);
         chk($sformatf("vec%0d_dz", i), 32'(rdz), 32'(vt[i].dz));
      end

      // Abort mid-multiply
      @(negedge clk);
      m.wr_hi = 1'b1;
      m.din   = 32'h11;
      @(negedge clk);
      m.wr_hi = 1'b0;
      m.wr_lo = 1'b1;
      m.din   = 32'h22;
      @(negedge clk);
      m.wr_lo = 1'b0;
      m.start = 1'b1;
      m.op    = OP_MULT;
      m.a     = 32'd3;
      m.b     = 32'd4;
      for (int n = 1; n <= 10; n++) begin
         @(negedge clk);
         m.start = 1'b0;
      end
      chk("abort_busy_before", 32'(m.busy), 32'd1);
      m.abort = 1'b1;
      @(negedge clk);
      m.abort = 1'b0;
      chk("abort_busy_after", 32'(m.busy), 32'd0);
      seen = 0;
      for (int n = 0; n < 40; n++) begin
         @(negedge clk);
         if (m.done) seen++;
      end
      chk("abort_no_done", 32'(seen), 32'd0);
      chk("abort_hi", m.hi, 32'h11);
      chk("abort_lo", m.lo, 32'h22);

      // Abort in IDLE drops a simultaneous Start
      m.start = 1'b1;
      m.abort = 1'b1;
      @(negedge clk);
      m.start = 1'b0;
      m.abort = 1'b0;
      chk("idle_abort_drops_start", 32'(m.busy), 32'd0);

      // Reset mid-multiply clears immediately
      m.start = 1'b1;
      m.op    = OP_MULT;
      for (int n = 1; n <= 10; n++) begin
         @(negedge clk);
         m.start = 1'b0;
      end
      rst = 1'b1;
      #1;
      chk("reset_mid_hi",   m.hi, 32'd0);
      chk("reset_mid_lo",   m.lo, 32'd0);
      chk("reset_mid_busy", 32'(m.busy), 32'd0);
      chk("reset_mid_done", 32'(m.done), 32'd0);
      @(negedge clk);
      rst = 1'b0;

      // Start and WrHi while busy are ignored, including Start in the DONE cycle
      @(negedge clk);
      m.wr_hi = 1'b1;
      m.din   = 32'h77;
      @(negedge clk);
      m.wr_hi = 1'b0;
      m.start = 1'b1;
      m.op    = OP_MULTU;
      m.a     = 32'd3;
      m.b     = 32'd5;
      cyc = -1;
      for (int n = 1; n <= 100 && cyc < 0; n++) begin
         @(negedge clk);
         m.start = 1'b0;
         m.wr_hi = 1'b0;
         if (n == 1) chk("busy_cycle1", 32'(m.busy), 32'd1);
         if (n == 5) begin
            m.start = 1'b1;
            m.a     = 32'd100;
            m.b     = 32'd100;
            m.wr_hi = 1'b1;
            m.din   = 32'hDEAD;
         end
         if (n == 6) chk("busy_wrhi_ignored", m.hi, 32'h77);
         if (m.done) begin
            cyc = n;
            chk("ign_hi", m.hi, 32'd0);
            chk("ign_lo", m.lo, 32'd15);
            chk("busy_in_done", 32'(m.busy), 32'd1);
            m.start = 1'b1;
         end
      end
      chk("ign_cycle", 32'(cyc), 32'd35);
      @(negedge clk);
      m.start = 1'b0;
      chk("done_start_ignored", 32'(m.busy), 32'd0);
      @(negedge clk);
      chk("after_done_idle", 32'(m.busy), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
